// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N input vectors through an external function and captures its truth table.
// Optional TRUTH_TABLE_CHECK_EN adds a reference-table compare (expected, err_count, pass).
module truth_table_sweeper #(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N-1:0]      vec,
    input  logic              f,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   table_out
`ifdef TRUTH_TABLE_CHECK_EN
    ,
    input  logic [2**N-1:0]   expected,
    output logic [N:0]        err_count,
    output logic              pass
`endif
);

    localparam int unsigned TW = 2**N;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    vec_d;
    logic            busy_d;
    logic            done_d;
    logic [TW-1:0]   table_d;
    logic            sample_c;
    logic            last_c;

`ifdef TRUTH_TABLE_CHECK_EN
    logic [N:0]      err_d;
    logic            pass_d;
`endif

    assign sample_c = (state_q == RUN) && (cnt_q == CW'(SETTLE));
    assign last_c   = (vec == {N{1'b1}});

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec;
        busy_d  = busy;
        done_d  = 1'b0;
        table_d = table_out;
`ifdef TRUTH_TABLE_CHECK_EN
        err_d   = err_count;
        pass_d  = pass;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    cnt_d   = '0;
                    table_d = '0;
                    busy_d  = 1'b1;
`ifdef TRUTH_TABLE_CHECK_EN
                    err_d   = '0;
                    pass_d  = 1'b0;
`endif
                end
            end
            RUN: begin
                if (sample_c) begin
                    table_d[vec] = f;
                    cnt_d        = '0;
`ifdef TRUTH_TABLE_CHECK_EN
                    if (f != expected[vec]) begin
                        err_d = err_count + (N+1)'(1);
                    end
`endif
                    if (last_c) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vec_d   = '0;
`ifdef TRUTH_TABLE_CHECK_EN
                        pass_d  = (err_d == '0);
`endif
                    end else begin
                        vec_d = vec + N'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
`ifdef TRUTH_TABLE_CHECK_EN
            err_count <= '0;
            pass      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec       <= vec_d;
            busy      <= busy_d;
            done      <= done_d;
            table_out <= table_d;
`ifdef TRUTH_TABLE_CHECK_EN
            err_count <= err_d;
            pass      <= pass_d;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper across three N/SETTLE builds.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    // u_a: N=4 SETTLE=1, u_b: N=4 SETTLE=0, u_c: N=2 SETTLE=3
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [3:0]  vec_a, vec_b;
    logic [1:0]  vec_c;
    logic        f_a, f_b, f_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [15:0] tab_a, tab_b;
    logic [3:0]  tab_c;
    logic [15:0] tt_a = '0, tt_b = '0;
    logic [3:0]  tt_c = '0;

    assign f_a = tt_a[vec_a];
    assign f_b = tt_b[vec_b];
    assign f_c = tt_c[vec_c];

    int vectors = 0;
    int miscompares = 0;

`ifdef TRUTH_TABLE_CHECK_EN
    logic [15:0] exp_a = '0, exp_b = '0;
    logic [3:0]  exp_c = '0;
    logic [4:0]  err_a, err_b;
    logic [2:0]  err_c;
    logic        pass_a, pass_b, pass_c;
`endif

    truth_table_sweeper #(.N(4), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .f(f_a),
        .busy(busy_a), .done(done_a), .table_out(tab_a)
`ifdef TRUTH_TABLE_CHECK_EN
        , .expected(exp_a), .err_count(err_a), .pass(pass_a)
`endif
    );

    truth_table_sweeper #(.N(4), .SETTLE(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .f(f_b),
        .busy(busy_b), .done(done_b), .table_out(tab_b)
`ifdef TRUTH_TABLE_CHECK_EN
        , .expected(exp_b), .err_count(err_b), .pass(pass_b)
`endif
    );

    truth_table_sweeper #(.N(2), .SETTLE(3)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .vec(vec_c), .f(f_c),
        .busy(busy_c), .done(done_c), .table_out(tab_c)
`ifdef TRUTH_TABLE_CHECK_EN
        , .expected(exp_c), .err_count(err_c), .pass(pass_c)
`endif
    );

    // Per-instance configuration used by the reference model
    function automatic int cfg_n(input int w);
        return (w == 2) ? 2 : 4;
    endfunction
    function automatic int cfg_s(input int w);
        case (w)
            0: return 1;
            1: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction
    function automatic logic get_busy(input int w);
        case (w)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction
    function automatic logic [15:0] get_table(input int w);
        case (w)
            0: return tab_a;
            1: return tab_b;
            default: return {12'h000, tab_c};
        endcase
    endfunction
    function automatic logic [3:0] get_vec(input int w);
        case (w)
            0: return vec_a;
            1: return vec_b;
            default: return {2'b00, vec_c};
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic set_tt(input int w, input logic [15:0] v);
        case (w)
            0: tt_a = v;
            1: tt_b = v;
            default: tt_c = v[3:0];
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one sweep and return the edge (relative to the start edge) where done rose
    task automatic sweep(input int w, input int max_cyc, output int done_at, output int busy_cnt);
        repeat (2) tick();
        set_start(w, 1'b1);
        tick();
        set_start(w, 1'b0);
        done_at  = -1;
        busy_cnt = get_busy(w) ? 1 : 0;
        for (int k = 1; k <= max_cyc; k++) begin
            tick();
            if (get_done(w)) begin
                done_at = k;
                break;
            end
            if (get_busy(w)) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int w = 0; w < 3; w++) begin
            vectors++;
            if ({get_busy(w), get_done(w)} !== 2'b00 || get_vec(w) !== 4'h0 || get_table(w) !== 16'h0) begin
                miscompares++;
                $display("FAIL reset[%0d]: busy=%b done=%b vec=%h table=%h, required all zero",
                         w, get_busy(w), get_done(w), get_vec(w), get_table(w));
            end
        end
`ifdef TRUTH_TABLE_CHECK_EN
        vectors++;
        if (err_a !== 5'd0 || pass_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_check: err=%0d pass=%b, required 0/0", err_a, pass_a);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    // Alternating function f = vec[0] on N=4, SETTLE=1
    task automatic test_alternating();
        int done_at, busy_cnt;
        set_tt(0, 16'hAAAA);
        sweep(0, 40, done_at, busy_cnt);
        vectors++;
        if (done_at !== 32 || busy_cnt !== 32) begin
            miscompares++;
            $display("FAIL alt_latency: done_at=%0d busy_cycles=%0d, required 32/32", done_at, busy_cnt);
        end
        vectors++;
        if (tab_a !== 16'hAAAA || busy_a !== 1'b0 || vec_a !== 4'h0) begin
            miscompares++;
            $display("FAIL alt_table: table=%h busy=%b vec=%h, required aaaa/0/0", tab_a, busy_a, vec_a);
        end
        tick();
        vectors++;
        if (done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL alt_done_width: done=%b, required 0", done_a);
        end
        repeat (5) tick();
        vectors++;
        if (tab_a !== 16'hAAAA || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL alt_hold: table=%h busy=%b, required aaaa/0", tab_a, busy_a);
        end
    endtask

    // (a&b)|(c&~d) on N=4, SETTLE=0
    task automatic test_settle0();
        int done_at, busy_cnt;
        logic [15:0] model;
        for (int i = 0; i < 16; i++) begin
            logic a, b, c, d;
            a = i[3]; b = i[2]; c = i[1]; d = i[0];
            model[i] = (a & b) | (c & ~d);
        end
        set_tt(1, model);
        sweep(1, 30, done_at, busy_cnt);
        vectors++;
        if (done_at !== 16 || tab_b !== 16'hF444) begin
            miscompares++;
            $display("FAIL settle0: done_at=%0d table=%h, required 16/f444", done_at, tab_b);
        end
    endtask

    // Random tables on every build; latency and table from the model
    task automatic test_random();
        int done_at, busy_cnt;
        logic [15:0] r, want;
        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < 3; w++) begin
                int lat;
                r = 16'($urandom);
                set_tt(w, r);
                want = (cfg_n(w) == 2) ? {12'h000, r[3:0]} : r;
                lat  = (1 << cfg_n(w)) * (cfg_s(w) + 1);
                sweep(w, lat + 10, done_at, busy_cnt);
                vectors++;
                if (done_at !== lat || busy_cnt !== lat || get_table(w) !== want) begin
                    miscompares++;
                    $display("FAIL random[%0d]: done_at=%0d busy=%0d table=%h, required %0d/%0d/%h",
                             w, done_at, busy_cnt, get_table(w), lat, lat, want);
                end
            end
        end
    endtask

    // Start held high: second sweep begins right after the DONE cycle
    task automatic test_back_to_back();
        int done_at;
        logic [15:0] r;
        r = 16'($urandom) | 16'h0001;
        set_tt(0, r);
        repeat (2) tick();
        start_a = 1'b1;
        tick();
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_a) begin done_at = k; break; end
        end
        vectors++;
        if (done_at !== 32 || tab_a !== r) begin
            miscompares++;
            $display("FAIL b2b_first: done_at=%0d table=%h, required 32/%h", done_at, tab_a, r);
        end
        tick();
        vectors++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || tab_a !== r) begin
            miscompares++;
            $display("FAIL b2b_gap: done=%b busy=%b table=%h, required 0/0/%h", done_a, busy_a, tab_a, r);
        end
        tick();
        vectors++;
        if (busy_a !== 1'b1 || tab_a !== 16'h0 || vec_a !== 4'h0) begin
            miscompares++;
            $display("FAIL b2b_restart: busy=%b table=%h vec=%h, required 1/0000/0", busy_a, tab_a, vec_a);
        end
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_a) begin done_at = k; break; end
        end
        start_a = 1'b0;
        vectors++;
        if (done_at !== 32 || tab_a !== r) begin
            miscompares++;
            $display("FAIL b2b_second: done_at=%0d table=%h, required 32/%h", done_at, tab_a, r);
        end
        repeat (2) tick();
    endtask

    // Reset mid-run aborts with no done pulse and a cleared table
    task automatic test_abort();
        bit saw_done;
        set_tt(0, 16'hAAAA);
        repeat (2) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (tab_a !== 16'h0 || vec_a !== 4'h0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: table=%h vec=%h busy=%b done=%b, required all zero",
                     tab_a, vec_a, busy_a, done_a);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done_a || busy_a) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_quiet: activity seen=%b, required 0", saw_done);
        end
    endtask

    // N=2, SETTLE=3: each vector held four cycles
    task automatic test_settle3();
        set_tt(2, 16'h0006);
        repeat (2) tick();
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            vectors++;
            if (vec_c !== 2'(k / 4) || done_c !== 1'b0 || busy_c !== 1'b1) begin
                miscompares++;
                $display("FAIL settle3_hold[%0d]: vec=%0d done=%b busy=%b, required %0d/0/1",
                         k, vec_c, done_c, busy_c, k / 4);
            end
        end
        tick();
        vectors++;
        if (done_c !== 1'b1 || tab_c !== 4'b0110 || vec_c !== 2'd0) begin
            miscompares++;
            $display("FAIL settle3_done: done=%b table=%b vec=%0d, required 1/0110/0", done_c, tab_c, vec_c);
        end
        repeat (2) tick();
    endtask

`ifdef TRUTH_TABLE_CHECK_EN
    // Reference compare: error count is the popcount of the difference
    task automatic test_check();
        int done_at, busy_cnt;
        logic [15:0] exps [4];
        logic [15:0] tts [4];
        exps[0] = 16'hAAAB; tts[0] = 16'hAAAA;
        exps[1] = 16'hAAAA; tts[1] = 16'hAAAA;
        tts[2] = 16'($urandom); exps[2] = tts[2] ^ 16'($urandom);
        tts[3] = 16'($urandom); exps[3] = tts[3] ^ (16'h1 << $urandom_range(15, 0));
        for (int i = 0; i < 4; i++) begin
            int want_err;
            logic want_pass;
            set_tt(0, tts[i]);
            exp_a = exps[i];
            want_err  = $countones(tts[i] ^ exps[i]);
            want_pass = (want_err == 0);
            sweep(0, 40, done_at, busy_cnt);
            vectors++;
            if (done_at !== 32 || err_a !== 5'(want_err) || pass_a !== want_pass) begin
                miscompares++;
                $display("FAIL check[%0d]: done_at=%0d err=%0d pass=%b, required 32/%0d/%b",
                         i, done_at, err_a, pass_a, want_err, want_pass);
            end
            repeat (3) tick();
            vectors++;
            if (err_a !== 5'(want_err) || pass_a !== want_pass) begin
                miscompares++;
                $display("FAIL check_hold[%0d]: err=%0d pass=%b, required %0d/%b",
                         i, err_a, pass_a, want_err, want_pass);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alternating();
        test_settle0();
        test_random();
        test_back_to_back();
        test_abort();
        test_settle3();
`ifdef TRUTH_TABLE_CHECK_EN
        test_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
